// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer and the ID-stage decoder.
package hazard_pkg;

  localparam int REG_AW_DEF  = 5;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hz_state_e;

  // ALUOp field driven by the main decoder into EX.
  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10
  } aluop_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic if_flush;
    logic freeze;
  } hz_ctrl_t;

  function automatic logic reg_hit(input logic use_rs, input logic [31:0] rs,
                                   input logic [31:0] rd);
    return use_rs && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module hazard_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stall, branch flush and memory-wait freeze with watchdog.
// Define HAZARD_PERF_CNT_EN to build the stall/flush/freeze performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ID_rs1_i,
  input  logic [REG_AW-1:0] ID_rs2_i,
  input  logic              ID_use_rs1_i,
  input  logic              ID_use_rs2_i,
  input  logic              ID_branch_taken_i,
  input  logic              EX_MemRead_i,
  input  logic [REG_AW-1:0] EX_rd_i,
  input  logic              MEM_req_i,
  input  logic              mem_ack_i,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              IDEX_bubble_o,
  output logic              IF_flush_o,
  output logic              freeze_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  freeze_cnt_o
);

  hz_state_e        state;
  logic [CNT_W-1:0] wait_cnt;
  logic             miss;
  logic             lu;
  logic             freeze;
  hz_ctrl_t         ctrl;

  assign miss = MEM_req_i & ~mem_ack_i;

  assign lu = EX_MemRead_i && (EX_rd_i != '0) &&
              (reg_hit(ID_use_rs1_i, 32'(ID_rs1_i), 32'(EX_rd_i)) ||
               reg_hit(ID_use_rs2_i, 32'(ID_rs2_i), 32'(EX_rd_i)));

  // An unencodable state is treated as a fault and parks in HALT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (miss) begin
            state    <= MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ack_i) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_cnt == CNT_W'(TIMEOUT)) begin
              state <= HALT;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

  always_comb begin
    freeze = 1'b1;
    case (state)
      RUN:      freeze = miss;
      MEM_WAIT: freeze = ~mem_ack_i;
      default:  freeze = 1'b1;
    endcase
  end

  // Outputs are same-cycle; reset overrides so the pipe sees a NOP stream while rst_i is high.
  always_comb begin
    ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0, if_flush: 1'b0, freeze: 1'b0};
    if (rst_i) begin
      ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1, if_flush: 1'b0, freeze: 1'b0};
    end else if (freeze) begin
      ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b0, if_flush: 1'b0, freeze: 1'b1};
    end else if (lu) begin
      ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1, if_flush: 1'b0, freeze: 1'b0};
    end else if (ID_branch_taken_i) begin
      ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0, if_flush: 1'b1, freeze: 1'b0};
    end
  end

  assign PCWrite_o     = ctrl.pc_write;
  assign IFIDWrite_o   = ctrl.ifid_write;
  assign IDEX_bubble_o = ctrl.idex_bubble;
  assign IF_flush_o    = ctrl.if_flush;
  assign freeze_o      = ctrl.freeze;
  assign err_o         = (state == HALT);

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (lu & ~ctrl.freeze),
    .cnt_o (stall_cnt_o)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ctrl.if_flush),
    .cnt_o (flush_cnt_o)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (ctrl.freeze),
    .cnt_o (freeze_cnt_o)
  );
`else
  assign stall_cnt_o  = '0;
  assign flush_cnt_o  = '0;
  assign freeze_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with a short watchdog and 4-bit counters.
module tb_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Expected output pattern: {PCWrite, IFIDWrite, IDEX_bubble, IF_flush, freeze, err}.
  localparam logic [5:0] E_NORM   = 6'b110000;
  localparam logic [5:0] E_STALL  = 6'b001000;
  localparam logic [5:0] E_FLUSH  = 6'b110100;
  localparam logic [5:0] E_FREEZE = 6'b000010;
  localparam logic [5:0] E_HALT   = 6'b000011;
  localparam logic [5:0] E_RESET  = 6'b001000;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              use_rs1, use_rs2, br_taken, ex_memread, mem_req, mem_ack;
  logic              pc_write, ifid_write, idex_bubble, if_flush, freeze, err;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt, freeze_cnt;

  typedef struct {
    string            tag;
    logic [5:0]       ctrl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic [CNT_W-1:0] frz;
  } exp_t;

  exp_t             sb[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] m_stall = '0, m_flush = '0, m_freeze = '0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ID_rs1_i          (id_rs1),
    .ID_rs2_i          (id_rs2),
    .ID_use_rs1_i      (use_rs1),
    .ID_use_rs2_i      (use_rs2),
    .ID_branch_taken_i (br_taken),
    .EX_MemRead_i      (ex_memread),
    .EX_rd_i           (ex_rd),
    .MEM_req_i         (mem_req),
    .mem_ack_i         (mem_ack),
    .PCWrite_o         (pc_write),
    .IFIDWrite_o       (ifid_write),
    .IDEX_bubble_o     (idex_bubble),
    .IF_flush_o        (if_flush),
    .freeze_o          (freeze),
    .err_o             (err),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt),
    .freeze_cnt_o      (freeze_cnt)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && c != CNT_MAX) ? c + CNT_W'(1) : c;
  endfunction

  task automatic cmp(input string tag, input string name, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s.%s: observed %0h expected %0h", tag, name, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "PCWrite",    16'(pc_write),    16'(e.ctrl[5]));
      cmp(e.tag, "IFIDWrite",  16'(ifid_write),  16'(e.ctrl[4]));
      cmp(e.tag, "bubble",     16'(idex_bubble), 16'(e.ctrl[3]));
      cmp(e.tag, "flush",      16'(if_flush),    16'(e.ctrl[2]));
      cmp(e.tag, "freeze",     16'(freeze),      16'(e.ctrl[1]));
      cmp(e.tag, "err",        16'(err),         16'(e.ctrl[0]));
      cmp(e.tag, "stall_cnt",  16'(stall_cnt),   16'(e.stall));
      cmp(e.tag, "flush_cnt",  16'(flush_cnt),   16'(e.flush));
      cmp(e.tag, "freeze_cnt", 16'(freeze_cnt),  16'(e.frz));
    end
  endtask

  // Inputs are already driven; record the expectation, check mid-cycle, then advance.
  task automatic applyStimulus(input string tag, input logic [5:0] e);
    exp_t item;
    if (rst_i) begin
      m_stall  = '0;
      m_flush  = '0;
      m_freeze = '0;
    end
    item.tag   = tag;
    item.ctrl  = e;
    item.stall = PERF_EN ? m_stall  : '0;
    item.flush = PERF_EN ? m_flush  : '0;
    item.frz   = PERF_EN ? m_freeze : '0;
    sb.push_back(item);
    if (!rst_i) begin
      m_stall  = sat_inc(m_stall, e[3] & ~e[1]);
      m_flush  = sat_inc(m_flush, e[2]);
      m_freeze = sat_inc(m_freeze, e[1]);
    end
    @(negedge clk_i);
    checkOutput();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst_i = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; br_taken = 1'b0;
    ex_memread = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk_i);
    #1;

    applyStimulus("reset", E_RESET);
    rst_i = 1'b0;
    applyStimulus("idle", E_NORM);

    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; use_rs1 = 1'b1;
    applyStimulus("lu_rs1", E_STALL);
    ex_memread = 1'b0;
    applyStimulus("lu_done", E_NORM);
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    applyStimulus("x0_no_stall", E_NORM);
    ex_rd = 5'd7; id_rs1 = 5'd7; use_rs1 = 1'b0; id_rs2 = 5'd7; use_rs2 = 1'b1;
    applyStimulus("lu_rs2", E_STALL);
    use_rs2 = 1'b0;
    applyStimulus("unused_src", E_NORM);

    ex_memread = 1'b0; br_taken = 1'b1;
    applyStimulus("branch", E_FLUSH);
    ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; use_rs1 = 1'b1;
    applyStimulus("branch_lu", E_STALL);
    ex_memread = 1'b0;
    applyStimulus("branch_retry", E_FLUSH);

    br_taken = 1'b0; ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
    mem_req = 1'b1; mem_ack = 1'b0;
    applyStimulus("miss_lu", E_FREEZE);
    applyStimulus("wait1", E_FREEZE);
    applyStimulus("wait2", E_FREEZE);
    mem_ack = 1'b1;
    applyStimulus("ack_lu", E_STALL);
    ex_memread = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    applyStimulus("after_ack", E_NORM);

    mem_req = 1'b1; mem_ack = 1'b1;
    applyStimulus("hit", E_NORM);
    mem_ack = 1'b0;
    applyStimulus("miss", E_FREEZE);
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus($sformatf("wait_to%0d", i), E_FREEZE);
    end
    mem_req = 1'b0; mem_ack = 1'b1;
    applyStimulus("halt_ack", E_HALT);
    mem_ack = 1'b0; br_taken = 1'b1;
    applyStimulus("halt_br", E_HALT);
    br_taken = 1'b0; rst_i = 1'b1;
    applyStimulus("rst_halt", E_RESET);
    rst_i = 1'b0;
    applyStimulus("post_rst", E_NORM);

    br_taken = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus($sformatf("flush%0d", i), E_FLUSH);
    end
    br_taken = 1'b0;
    applyStimulus("flush_sat", E_NORM);

    mem_req = 1'b1; mem_ack = 1'b0;
    applyStimulus("miss2", E_FREEZE);
    applyStimulus("wait_r", E_FREEZE);
    rst_i = 1'b1;
    applyStimulus("rst_wait", E_RESET);
    rst_i = 1'b0; mem_req = 1'b0;
    applyStimulus("post_rst2", E_NORM);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RISC-V core.
- Takes decoded control (MemRead, Branch) and register addresses from ID/EX/MEM, plus the data-memory handshake.
- Drives PC/IF-ID write enables, ID/EX bubble insertion, IF flush and a whole-pipeline freeze.
- Owns the memory-wait FSM with a watchdog timeout.

Parameters:
- REG_AW, 5, register-address width.
- TIMEOUT, 255, max consecutive memory-wait cycles before HALT; must be ≥1 and < 2^CNT_W.
- CNT_W, 16, width of the wait counter and the perf counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ID_rs1_i  in  REG_AW  rs1 of the instruction in ID.
- ID_rs2_i  in  REG_AW  rs2 of the instruction in ID.
- ID_use_rs1_i  in  1  ID instruction reads rs1.
- ID_use_rs2_i  in  1  ID instruction reads rs2.
- ID_branch_taken_i  in  1  branch resolved taken in ID.
- EX_MemRead_i  in  1  EX-stage instruction is a load.
- EX_rd_i  in  REG_AW  EX-stage destination register.
- MEM_req_i  in  1  MEM stage issuing a load or store this cycle.
- mem_ack_i  in  1  data memory completes the request this cycle.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID register write enable.
- IDEX_bubble_o  out  1  force ID/EX control bits to zero (NOP).
- IF_flush_o  out  1  zero the IF/ID instruction.
- freeze_o  out  1  hold every pipeline register, including EX/MEM and MEM/WB.
- err_o  out  1  memory watchdog fired; sticky until reset.
- stall_cnt_o  out  CNT_W  load-use stall cycles (PERF_CNT_EN only).
- flush_cnt_o  out  CNT_W  flushes (PERF_CNT_EN only).
- freeze_cnt_o  out  CNT_W  freeze cycles (PERF_CNT_EN only).

Behaviour:
- Clocking: single clock clk_i; rst_i is asynchronous, active-high.
- While rst_i is high:
  - state=RUN, wait_cnt=0, err_o=0.
  - PCWrite_o=0, IFIDWrite_o=0, IDEX_bubble_o=1, IF_flush_o=0, freeze_o=0, all counters 0.
- State register: RUN, MEM_WAIT, HALT. Outputs are Mealy (same-cycle) so the pipeline reacts without added latency.
- miss = MEM_req_i & ~mem_ack_i.
- RUN:
  - If miss: freeze_o=1 this cycle, next state MEM_WAIT, wait_cnt←1.
  - Else freeze_o=0.
- MEM_WAIT:
  - freeze_o = ~mem_ack_i.
  - mem_ack_i=1: next state RUN, wait_cnt←0. The pipeline advances in this same cycle.
  - mem_ack_i=0: wait_cnt increments; when wait_cnt==TIMEOUT, next state HALT.
  - MEM_req_i is ignored here; it is held stable by the freeze.
- HALT: freeze_o=1, PCWrite_o=0, IFIDWrite_o=0, err_o=1. Exit only via rst_i.
- Load-use stall (lu):
  - lu = EX_MemRead_i & (EX_rd_i≠0) & ((ID_use_rs1_i & EX_rd_i==ID_rs1_i) | (ID_use_rs2_i & EX_rd_i==ID_rs2_i)).
  - x0 never causes a stall.
- Priority, highest first:
  1. freeze_o=1 → PCWrite_o=0, IFIDWrite_o=0, IDEX_bubble_o=0, IF_flush_o=0 (whole pipe holds; lu is re-evaluated after the freeze).
  2. lu → PCWrite_o=0, IFIDWrite_o=0, IDEX_bubble_o=1, IF_flush_o=0. A taken branch in ID is suppressed and re-resolved next cycle with forwarded data.
  3. ID_branch_taken_i → PCWrite_o=1, IFIDWrite_o=1, IF_flush_o=1, IDEX_bubble_o=0.
  4. Otherwise PCWrite_o=1, IFIDWrite_o=1, IDEX_bubble_o=0, IF_flush_o=0.
- A load-use stall lasts exactly one cycle per hazard, because the bubble moves the load to MEM.
- Simultaneous miss and lu: the freeze wins. After the ack, lu is still true and stalls one cycle.
- rst_i asserted mid-MEM_WAIT or in HALT returns immediately to the reset values.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt_o +1 per cycle with lu active and no freeze.
  - flush_cnt_o +1 per IF_flush_o cycle.
  - freeze_cnt_o +1 per freeze_o cycle.
  - All counters saturate at 2^CNT_W−1 (no wrap) and clear on reset.
- Undefined: the three ports remain in the interface, tied to 0, with no counter flops.

Decomposition:
- Package hazard_pkg holds:
  - State enum (RUN=2'b00, MEM_WAIT=2'b01, HALT=2'b10).
  - Default REG_AW/TIMEOUT/CNT_W constants.
  - The ALUOp encodings already shared with the decoder.
- Sub-module hazard_perf_cnt: a saturating counter with inc_i, instantiated three times under the macro.

Test Plan:
- lw x5 in EX (EX_MemRead_i=1, EX_rd_i=5), ID_rs1_i=5, use_rs1=1 → one cycle with PCWrite_o=0, IFIDWrite_o=0, IDEX_bubble_o=1; next cycle all normal.
- EX_rd_i=0 with EX_MemRead_i=1 and ID_rs1_i=0 → no stall; PCWrite_o=1.
- ID_branch_taken_i=1 and no hazard → IF_flush_o=1 for one cycle. Same cycle with lu → IF_flush_o=0, bubble=1; next cycle flush=1.
- MEM_req_i=1, mem_ack_i low for 3 cycles then high → freeze_o=1 for 3 cycles, 0 on the ack cycle; state returns to RUN; freeze_cnt_o=3 with PERF_CNT_EN.
- TIMEOUT=4, mem_ack_i held 0 → HALT after 4 wait cycles; err_o=1 and freeze_o=1 persist. Asserting rst_i asynchronously mid-cycle clears err_o immediately.
- PERF_CNT_EN with CNT_W=4 and 20 flushes → flush_cnt_o saturates at 15.
